// File: rtl/theta_tracker.sv
// theta_tracker: derives the POV slice index from a once-per-revolution hall index pulse.
// Each measured revolution length is split into ROTATIONAL_RES slices, remainder spread evenly.
module theta_tracker #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int PERIOD_WIDTH = 32,
  parameter int MIN_PERIOD = 2 * ROTATIONAL_RES,
  parameter logic [PERIOD_WIDTH-1:0] TIMEOUT = {1'b1, {(PERIOD_WIDTH-1){1'b0}}}
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                hall_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0]   theta,
  output logic                                locked,
  output logic                                slice_strobe,
  output logic                                rev_strobe,
  output logic [PERIOD_WIDTH-1:0]             period
);

  localparam int L = $clog2(ROTATIONAL_RES);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P  = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] MIN_M1 = PERIOD_WIDTH'(MIN_PERIOD - 1);
  localparam logic [PERIOD_WIDTH-1:0] TO_M1  = TIMEOUT - ONE_P;
  localparam logic [L:0]              RES_W  = ROTATIONAL_RES[L:0];
  localparam logic [L-1:0]            THETA_MAX = '1;
  localparam logic [L-1:0]            THETA_ONE = L'(1);

  typedef enum logic [1:0] {UNSEEN, MEASURE, LOCKED} state_t;

  state_t                  state_q;
  logic                    sync0_q, sync1_q, sync2_q, rise_q;
  logic [PERIOD_WIDTH-1:0] since_q, period_q, cnt_q;
  logic [L-1:0]            theta_q;
  logic [L:0]              acc_q;
  logic                    xtra_q, locked_q, slice_q, rev_q;

  logic                    accept_d, timeout_d, slice_end_d;
  logic [PERIOD_WIDTH-1:0] new_period_d, base_d;
  logic [L:0]              rem_d, sum_d;

  always_comb begin
    accept_d     = rise_q && ((state_q == UNSEEN) || (since_q >= MIN_M1));
    timeout_d    = since_q >= TO_M1;
    new_period_d = since_q + ONE_P;
    base_d       = period_q >> L;
    rem_d        = {1'b0, period_q[L-1:0]};
    sum_d        = acc_q + rem_d;
    slice_end_d  = (cnt_q + ONE_P) == (base_d + {{(PERIOD_WIDTH-1){1'b0}}, xtra_q});
  end

  // acc_q holds the accumulator after the current slice was evaluated; xtra_q is that slice's extra cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= UNSEEN;
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      rise_q   <= 1'b0;
      since_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      theta_q  <= '0;
      acc_q    <= '0;
      xtra_q   <= 1'b0;
      locked_q <= 1'b0;
      slice_q  <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      sync0_q <= hall_in;
      sync1_q <= sync0_q;
      sync2_q <= sync1_q;
      rise_q  <= sync1_q & ~sync2_q;
      rev_q   <= accept_d;
      slice_q <= 1'b0;
      if (since_q != '1) since_q <= since_q + ONE_P;

      if (accept_d) begin
        since_q <= '0;
        theta_q <= '0;
        cnt_q   <= '0;
        xtra_q  <= 1'b0;
        if (state_q == UNSEEN) begin
          state_q <= MEASURE;
          acc_q   <= '0;
        end else begin
          // Slice 0 starts with an empty accumulator, so it never takes the extra cycle.
          state_q  <= LOCKED;
          period_q <= new_period_d;
          acc_q    <= {1'b0, new_period_d[L-1:0]};
          locked_q <= 1'b1;
          slice_q  <= 1'b1;
        end
      end else if (timeout_d) begin
        state_q  <= UNSEEN;
        locked_q <= 1'b0;
        theta_q  <= '0;
        period_q <= '0;
        cnt_q    <= '0;
        acc_q    <= '0;
        xtra_q   <= 1'b0;
      end else if ((state_q == LOCKED) && (theta_q != THETA_MAX)) begin
        if (slice_end_d) begin
          theta_q <= theta_q + THETA_ONE;
          cnt_q   <= '0;
          slice_q <= 1'b1;
          if (sum_d >= RES_W) begin
            xtra_q <= 1'b1;
            acc_q  <= sum_d - RES_W;
          end else begin
            xtra_q <= 1'b0;
            acc_q  <= sum_d;
          end
        end else begin
          cnt_q <= cnt_q + ONE_P;
        end
      end
    end
  end

  assign theta        = theta_q;
  assign locked       = locked_q;
  assign slice_strobe = slice_q;
  assign rev_strobe   = rev_q;
  assign period       = period_q;

endmodule

// File: tb/tb_theta_tracker.sv
// Bench for theta_tracker: pulse trains with a closed-form reference model (slice k starts at floor(k*P/RES)).
module tb_theta_tracker;
  localparam int          RES  = 1024;
  localparam int          MINP = 2048;
  localparam logic [31:0] TO   = 32'd10000;

  logic        clk = 1'b0;
  logic        rst, hall;
  logic [9:0]  theta;
  logic        locked, slice_strobe, rev_strobe;
  logic [31:0] period;
  int          total, bad;

  theta_tracker #(.ROTATIONAL_RES(RES), .PERIOD_WIDTH(32), .MIN_PERIOD(MINP), .TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst), .hall_in(hall), .theta(theta), .locked(locked),
    .slice_strobe(slice_strobe), .rev_strobe(rev_strobe), .period(period));

  always #5 clk = ~clk;

  // Reference model: edges from raw hall samples (3-cycle latency), theta from elapsed time.
  longint      k_m = 0, last_m = 0, e_m = 0, tc;
  int          st_m = 0;
  logic [4:0]  hq = '0;
  logic        acc_m;
  logic [9:0]  m_theta = '0, prev_m;
  logic        m_locked = 1'b0, m_slice = 1'b0, m_rev = 1'b0;
  logic [31:0] m_period = '0;

  always @(posedge clk) begin
    k_m++;
    hq = {hq[3:0], hall};
    if (rst) begin
      hq = '0; st_m = 0; last_m = k_m;
      m_theta = '0; m_locked = 1'b0; m_slice = 1'b0; m_rev = 1'b0; m_period = '0;
    end else begin
      acc_m  = hq[3] && !hq[4] && (st_m == 0 || (k_m - last_m) >= MINP);
      prev_m = m_theta;
      m_rev  = acc_m;
      if (acc_m) begin
        if (st_m == 0) st_m = 1;
        else begin
          m_period = 32'(k_m - last_m);
          st_m = 2;
          e_m = k_m;
        end
        last_m = k_m;
      end else if ((k_m - last_m) >= longint'(TO)) begin
        st_m = 0;
        m_period = '0;
      end
      m_locked = (st_m == 2);
      if (m_locked) begin
        tc = ((k_m - e_m + 1) * RES - 1) / longint'(m_period);
        if (tc > RES - 1) tc = RES - 1;
        m_theta = tc[9:0];
        m_slice = acc_m || (m_theta != prev_m);
      end else begin
        m_theta = '0;
        m_slice = 1'b0;
      end
    end
  end

  task automatic tick(input bit h);
    hall = h;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(0); tick(0); rst = 1'b0;
    total++;
    if ({theta, locked, slice_strobe, rev_strobe, period} !== 45'd0) begin
      bad++; $display("FAIL reset_state got theta=%0d locked=%b ss=%b rs=%b period=%0d want all 0", theta, locked, slice_strobe, rev_strobe, period);
    end
    for (int i = 0; i < 100; i++) begin
      tick(0);
      total++;
      if ({theta, locked, slice_strobe, rev_strobe, period} !== 45'd0) begin
        bad++; $display("FAIL idle cyc=%0d got theta=%0d locked=%b ss=%b rs=%b period=%0d want all 0", i, theta, locked, slice_strobe, rev_strobe, period);
      end
    end
  endtask

  task automatic test_lock_4096();
    int nrev = 0, nss = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4096; i++) begin
        tick(i < 8);
        total++;
        if ({theta, locked, slice_strobe, rev_strobe, period} !== {m_theta, m_locked, m_slice, m_rev, m_period}) begin
          bad++; $display("FAIL lock4096 t=%0t got/want theta=%0d/%0d locked=%b/%b ss=%b/%b rs=%b/%b period=%0d/%0d", $time, theta, m_theta, locked, m_locked, slice_strobe, m_slice, rev_strobe, m_rev, period, m_period);
        end
        if (rev_strobe) begin
          nrev++;
          if (nrev == 2) begin
            total++;
            if (locked !== 1'b1 || period !== 32'd4096) begin
              bad++; $display("FAIL lock_after_2nd got locked=%b period=%0d want 1 4096", locked, period);
            end
          end
          if (nrev == 3) begin
            total++;
            if (nss !== 1024) begin
              bad++; $display("FAIL strobes_per_rev got %0d want 1024", nss);
            end
          end
          nss = 0;
        end
        nss += int'(slice_strobe);
      end
    end
  endtask

  task automatic test_remainder();
    int nrev = 0, n4 = 0, n5 = 0, nother = 0, c = 0, last = 0;
    bit active = 0;
    logic [9:0] prev_theta = '0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4100; i++) begin
        tick(i < 8);
        c++;
        total++;
        if ({theta, locked, slice_strobe, rev_strobe, period} !== {m_theta, m_locked, m_slice, m_rev, m_period}) begin
          bad++; $display("FAIL rem4100 t=%0t got/want theta=%0d/%0d locked=%b/%b ss=%b/%b rs=%b/%b period=%0d/%0d", $time, theta, m_theta, locked, m_locked, slice_strobe, m_slice, rev_strobe, m_rev, period, m_period);
        end
        if (slice_strobe && active) begin
          if (c - last == 4) n4++;
          else if (c - last == 5) n5++;
          else nother++;
        end
        if (slice_strobe) last = c;
        if (rev_strobe) begin
          nrev++;
          if (nrev == 2) begin
            active = 1;
            total++;
            if (period !== 32'd4100) begin
              bad++; $display("FAIL period_4100 got %0d want 4100", period);
            end
          end else if (nrev == 3) begin
            active = 0;
            total++;
            if (n5 !== 4 || n4 !== 1020 || nother !== 0) begin
              bad++; $display("FAIL slice_mix got n5=%0d n4=%0d other=%0d want 4 1020 0", n5, n4, nother);
            end
            total++;
            if (prev_theta !== 10'd1023) begin
              bad++; $display("FAIL theta_before_edge got %0d want 1023", prev_theta);
            end
          end
        end
        prev_theta = theta;
      end
    end
  endtask

  task automatic test_late_index();
    int gaps[3] = '{4096, 5000, 4096};
    int nrev = 0, nhold = 0, nss = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < gaps[p]; i++) begin
        tick(i < 8);
        total++;
        if ({theta, locked, slice_strobe, rev_strobe, period} !== {m_theta, m_locked, m_slice, m_rev, m_period}) begin
          bad++; $display("FAIL late t=%0t got/want theta=%0d/%0d locked=%b/%b ss=%b/%b rs=%b/%b period=%0d/%0d", $time, theta, m_theta, locked, m_locked, slice_strobe, m_slice, rev_strobe, m_rev, period, m_period);
        end
        if (rev_strobe) begin
          nrev++;
          if (nrev == 3) begin
            total++;
            if (period !== 32'd5000 || nhold !== 908 || nss !== 1024) begin
              bad++; $display("FAIL late_hold got period=%0d hold=%0d strobes=%0d want 5000 908 1024", period, nhold, nss);
            end
          end
          nhold = 0; nss = 0;
        end
        nhold += int'(theta == 10'd1023);
        nss += int'(slice_strobe);
      end
    end
  endtask

  task automatic test_glitch();
    int nrev = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4096; i++) begin
        tick(i < 8 || (p == 0 && i >= 100 && i < 104));
        total++;
        if ({theta, locked, slice_strobe, rev_strobe, period} !== {m_theta, m_locked, m_slice, m_rev, m_period}) begin
          bad++; $display("FAIL glitch t=%0t got/want theta=%0d/%0d locked=%b/%b ss=%b/%b rs=%b/%b period=%0d/%0d", $time, theta, m_theta, locked, m_locked, slice_strobe, m_slice, rev_strobe, m_rev, period, m_period);
        end
        if (rev_strobe) nrev++;
      end
    end
    total++;
    if (nrev !== 2 || period !== 32'd4096) begin
      bad++; $display("FAIL glitch_reject got revs=%0d period=%0d want 2 4096", nrev, period);
    end
  endtask

  task automatic test_random();
    int prev_gap = 4096;
    for (int p = 0; p < 4; p++) begin
      int gap  = int'($urandom_range(3600, 2100));
      bit gl   = 1'($urandom_range(1, 0));
      int goff = int'($urandom_range(1500, 200));
      for (int i = 0; i < gap; i++) begin
        tick(i < 8 || (gl && i >= goff && i < goff + 3));
        total++;
        if ({theta, locked, slice_strobe, rev_strobe, period} !== {m_theta, m_locked, m_slice, m_rev, m_period}) begin
          bad++; $display("FAIL random t=%0t got/want theta=%0d/%0d locked=%b/%b ss=%b/%b rs=%b/%b period=%0d/%0d", $time, theta, m_theta, locked, m_locked, slice_strobe, m_slice, rev_strobe, m_rev, period, m_period);
        end
        if (rev_strobe) begin
          total++;
          if (period !== 32'(prev_gap) || theta !== 10'd0 || slice_strobe !== 1'b1) begin
            bad++; $display("FAIL random_edge got period=%0d theta=%0d ss=%b want %0d 0 1", period, theta, slice_strobe, prev_gap);
          end
        end
      end
      prev_gap = gap;
    end
  endtask

  task automatic test_timeout();
    int lens[3] = '{10100, 4096, 100};
    int nrev = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < lens[p]; i++) begin
        tick(i < 8);
        total++;
        if ({theta, locked, slice_strobe, rev_strobe, period} !== {m_theta, m_locked, m_slice, m_rev, m_period}) begin
          bad++; $display("FAIL timeout t=%0t got/want theta=%0d/%0d locked=%b/%b ss=%b/%b rs=%b/%b period=%0d/%0d", $time, theta, m_theta, locked, m_locked, slice_strobe, m_slice, rev_strobe, m_rev, period, m_period);
        end
        if (p == 0 && i == 9990) begin
          total++;
          if (locked !== 1'b1) begin
            bad++; $display("FAIL before_timeout got locked=%b want 1", locked);
          end
        end
        if (p == 0 && i == 10050) begin
          total++;
          if (locked !== 1'b0 || theta !== 10'd0 || period !== 32'd0) begin
            bad++; $display("FAIL after_timeout got locked=%b theta=%0d period=%0d want 0 0 0", locked, theta, period);
          end
        end
        if (rev_strobe) begin
          nrev++;
          if (nrev == 2) begin
            total++;
            if (locked !== 1'b0) begin
              bad++; $display("FAIL relock_first got locked=%b want 0", locked);
            end
          end
          if (nrev == 3) begin
            total++;
            if (locked !== 1'b1 || period !== 32'd4096) begin
              bad++; $display("FAIL relock_second got locked=%b period=%0d want 1 4096", locked, period);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midrev();
    for (int i = 0; i < 1000; i++) tick(0);
    total++;
    if ({theta, locked, period} !== {m_theta, m_locked, m_period} || locked !== 1'b1) begin
      bad++; $display("FAIL midrev_pre got theta=%0d locked=%b period=%0d want %0d 1 %0d", theta, locked, period, m_theta, m_period);
    end
    rst = 1'b1; tick(0);
    total++;
    if ({theta, locked, slice_strobe, rev_strobe, period} !== 45'd0) begin
      bad++; $display("FAIL midrev_reset got theta=%0d locked=%b ss=%b rs=%b period=%0d want all 0", theta, locked, slice_strobe, rev_strobe, period);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(0);
      total++;
      if ({theta, locked, slice_strobe, rev_strobe, period} !== 45'd0) begin
        bad++; $display("FAIL midrev_idle got theta=%0d locked=%b ss=%b rs=%b period=%0d want all 0", theta, locked, slice_strobe, rev_strobe, period);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    hall = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock_4096();
    test_remainder();
    test_late_index();
    test_glitch();
    test_random();
    test_timeout();
    test_reset_midrev();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
